// File: rtl/amp_i2c_master.sv
// I2C initiator for the amplifier control port: one register write or read per command.
// SCL is push-pull; SDA is open-drain (sdaoe=1 pulls low), with no clock stretching.
module amp_i2c_master #(
  parameter int CLK_DIV = 30
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       done,
  output logic       ack_err,
  output logic       busy,
  output logic       scl,
  input  logic       sdai,
  output logic       sdao,
  output logic       sdaoe
);
  // Command handshake: a command transfers on any cycle where cmd_valid and cmd_ready are both high;
  // cmd_ready is high only in IDLE, and the command fields are held internally until done.
  typedef enum logic [2:0] {IDLE, START, BYTE, ACK, RSTART, STOP, DONE} state_t;
  typedef enum logic [2:0] {SEL_DEVW, SEL_REG, SEL_WR, SEL_DEVR, SEL_RX} sel_t;

  localparam logic [7:0] QMAX = 8'(CLK_DIV - 1);

  state_t     state, state_nxt;
  sel_t       byte_sel, sel_nxt;
  logic [7:0] qcnt;
  logic [1:0] phase;
  logic [2:0] bit_idx;
  logic [7:0] sreg, load_byte;
  logic       samp, rw_q;
  logic [6:0] dev_q;
  logic [7:0] reg_q, wr_q;
  logic       quarter_end, state_end;

  assign quarter_end = (qcnt == QMAX);
  assign state_end   = quarter_end && (phase == 2'd3);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state    <= IDLE;
      byte_sel <= SEL_DEVW;
    end else begin
      state    <= state_nxt;
      byte_sel <= sel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = byte_sel;
    case (state)
      IDLE:   if (cmd_valid) state_nxt = START;
      START:  if (state_end) begin state_nxt = BYTE; sel_nxt = SEL_DEVW; end
      BYTE:   if (state_end && bit_idx == 3'd7) state_nxt = ACK;
      ACK: begin
        if (state_end) begin
          // samp holds the ACK bit; a NACK on any transmitted byte aborts to STOP
          if (byte_sel != SEL_RX && samp) begin
            state_nxt = STOP;
          end else begin
            case (byte_sel)
              SEL_DEVW: begin state_nxt = BYTE; sel_nxt = SEL_REG; end
              SEL_REG: begin
                if (rw_q) state_nxt = RSTART;
                else begin state_nxt = BYTE; sel_nxt = SEL_WR; end
              end
              SEL_DEVR: begin state_nxt = BYTE; sel_nxt = SEL_RX; end
              default:  state_nxt = STOP;
            endcase
          end
        end
      end
      RSTART: if (state_end) begin state_nxt = BYTE; sel_nxt = SEL_DEVR; end
      STOP:   if (state_end) state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (sel_nxt)
      SEL_DEVW: load_byte = {dev_q, 1'b0};
      SEL_REG:  load_byte = reg_q;
      SEL_WR:   load_byte = wr_q;
      SEL_DEVR: load_byte = {dev_q, 1'b1};
      default:  load_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      qcnt    <= '0;
      phase   <= '0;
      bit_idx <= '0;
      sreg    <= '0;
      samp    <= 1'b0;
      rw_q    <= 1'b0;
      dev_q   <= '0;
      reg_q   <= '0;
      wr_q    <= '0;
      ack_err <= 1'b0;
      rd_data <= '0;
    end else if (state == IDLE) begin
      qcnt    <= '0;
      phase   <= '0;
      bit_idx <= '0;
      if (cmd_valid) begin
        rw_q    <= cmd_rw;
        dev_q   <= dev_addr;
        reg_q   <= reg_addr;
        wr_q    <= wr_data;
        ack_err <= 1'b0;
      end
    end else begin
      if (quarter_end) begin
        qcnt  <= '0;
        phase <= phase + 2'd1;
      end else begin
        qcnt <= qcnt + 8'd1;
      end
      if (quarter_end && phase == 2'd2) samp <= sdai;
      if (state == BYTE && state_end) bit_idx <= bit_idx + 3'd1;
      // One register serves both directions: tx bits leave from the MSB, rx bits enter at the LSB
      if (state_nxt == BYTE && state != BYTE) sreg <= load_byte;
      else if (state == BYTE && state_end) sreg <= {sreg[6:0], samp};
      if (state == ACK && state_end && byte_sel != SEL_RX && samp) ack_err <= 1'b1;
      if (state == ACK && state_end && byte_sel == SEL_RX) rd_data <= sreg;
    end
  end

  always_comb begin
    scl   = 1'b1;
    sdaoe = 1'b0;
    case (state)
      START:  sdaoe = phase[1];
      BYTE: begin
        scl   = phase[1];
        sdaoe = (byte_sel != SEL_RX) && !sreg[7];
      end
      ACK:    scl = phase[1];
      RSTART: begin
        scl   = (phase != 2'd0);
        sdaoe = phase[1];
      end
      STOP: begin
        scl   = (phase != 2'd0);
        sdaoe = !phase[1];
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign sdao      = 1'b0;
endmodule

// File: tb/tb_amp_i2c_master.sv
// Bench for amp_i2c_master: behavioural I2C target on scl/sda, transaction-level model and
// per-cycle compare of the command interface, plus hand-computed checks per directed test.
module tb_amp_i2c_master;
  localparam int CLK_DIV = 4;
  localparam logic [9:0] TOK_S = 10'h100, TOK_P = 10'h200;
  localparam logic [9:0] TOK_MACK = 10'h300, TOK_MNACK = 10'h301;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_rw = 1'b0;
  logic [6:0] dev_addr = '0;
  logic [7:0] reg_addr = '0;
  logic [7:0] wr_data = '0;
  logic       cmd_ready, done, ack_err, busy, scl, sdao, sdaoe;
  logic [7:0] rd_data;
  logic       tgt_drive = 1'b1;
  logic       sda;

  assign sda = sdaoe ? 1'b0 : tgt_drive;

  amp_i2c_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .resetb(resetb), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .dev_addr(dev_addr), .reg_addr(reg_addr), .wr_data(wr_data),
    .rd_data(rd_data), .done(done), .ack_err(ack_err), .busy(busy),
    .scl(scl), .sdai(sda), .sdao(sdao), .sdaoe(sdaoe)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural I2C target ----------------
  logic [6:0] tgt_addr = 7'h2C;
  logic       tgt_nack_reg = 1'b0;
  logic [7:0] tgt_rd_val = 8'h00;
  logic [9:0] obs_q[$];
  int         pulse_cnt = 0;
  logic       p_scl = 1'b1, p_sda = 1'b1;
  logic       tx_mode = 1'b0, pend_tx = 1'b0, hi_clean = 1'b0, ack_b;
  int         bit_cnt = 0, byte_no = 0;
  logic [7:0] rx_sh = '0, tx_sh = '0;

  always @(negedge clk) begin
    logic c_sda;
    c_sda = sda;
    if (!resetb) begin
      tgt_drive = 1'b1; bit_cnt = 0; byte_no = 0;
      tx_mode = 1'b0; pend_tx = 1'b0; hi_clean = 1'b0;
    end else if (scl && p_scl && c_sda != p_sda) begin
      obs_q.push_back(c_sda ? TOK_P : TOK_S);
      bit_cnt = 0; byte_no = 0; tx_mode = 1'b0; pend_tx = 1'b0;
      hi_clean = 1'b0; tgt_drive = 1'b1;
    end else if (scl && !p_scl) begin
      hi_clean = 1'b1;
      if (bit_cnt < 8) begin
        if (!tx_mode) rx_sh = {rx_sh[6:0], c_sda};
      end else if (tx_mode) begin
        obs_q.push_back(c_sda ? TOK_MNACK : TOK_MACK);
      end
      bit_cnt++;
    end else if (!scl && p_scl) begin
      if (hi_clean) pulse_cnt++;
      hi_clean = 1'b0;
      if (bit_cnt == 8) begin
        if (tx_mode) tgt_drive = 1'b1;
        else begin
          obs_q.push_back({2'b00, rx_sh});
          if (byte_no == 0) ack_b = (rx_sh[7:1] == tgt_addr);
          else ack_b = !(byte_no == 1 && tgt_nack_reg);
          tgt_drive = !ack_b;
          pend_tx = ack_b && byte_no == 0 && rx_sh[0];
          byte_no++;
        end
      end else if (bit_cnt == 9) begin
        bit_cnt = 0;
        tx_mode = pend_tx;
        pend_tx = 1'b0;
        tx_sh = tgt_rd_val;
        tgt_drive = tx_mode ? tx_sh[7] : 1'b1;
      end else if (tx_mode && bit_cnt >= 1 && bit_cnt <= 7) begin
        tgt_drive = tx_sh[7 - bit_cnt];
      end
    end
    p_scl = scl;
    p_sda = c_sda;
  end

  // ---------------- model + per-cycle compare (scoreboard) ----------------
  logic [9:0] exp_q[$];
  logic       m_busy = 1'b0, m_err = 1'b0, m_ack = 1'b0, m_rd_upd = 1'b0;
  logic [7:0] m_rd = '0, m_rd_next = '0;
  int         m_since = 0, m_dur = 0, m_frames = 0, m_rs = 0;
  int         cyc = 0, n_acc = 0, n_done = 0, acc_cyc = 0, done_cyc = 0, last_lat = 0;

  always @(negedge clk) begin
    cyc++;
    if (!resetb) begin
      check("rst_scl", scl, 1);
      check("rst_sdaoe", sdaoe, 0);
      check("rst_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      m_busy = 1'b0; m_rd = '0; m_ack = 1'b0;
    end else if (m_busy) begin
      m_since++;
      check("busy_high", busy, 1);
      check("ready_low", cmd_ready, 0);
      check("sdao_zero", sdao, 0);
      if (done) begin
        last_lat = m_since; done_cyc = cyc; n_done++;
        check("latency_window", (m_since >= m_dur - 2 && m_since <= m_dur + 2), 1);
        if (m_rd_upd) m_rd = m_rd_next;
        m_ack = m_err;
        check("ack_err_at_done", ack_err, m_ack);
        check("rd_data_at_done", rd_data, m_rd);
        check("event_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
          check("bus_event", obs_q[i], exp_q[i]);
        check("scl_pulses", pulse_cnt, 9 * m_frames);
        m_busy = 1'b0;
      end else if (m_since > m_dur + 2) begin
        check("done_timeout", done, 1);
        m_busy = 1'b0;
      end
    end else begin
      check("idle_ready", cmd_ready, 1);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_scl", scl, 1);
      check("idle_sdaoe", sdaoe, 0);
      check("idle_ack_err", ack_err, m_ack);
      check("idle_rd_data", rd_data, m_rd);
      if (cmd_valid) begin
        m_busy = 1'b1; m_since = 0; n_acc++; acc_cyc = cyc;
        obs_q.delete(); exp_q.delete(); pulse_cnt = 0;
        m_rd_upd = 1'b0; m_rs = 0;
        exp_q.push_back(TOK_S);
        exp_q.push_back({2'b00, dev_addr, 1'b0});
        if (dev_addr != tgt_addr) begin
          m_frames = 1; m_err = 1'b1;
        end else begin
          exp_q.push_back({2'b00, reg_addr});
          if (tgt_nack_reg) begin
            m_frames = 2; m_err = 1'b1;
          end else if (!cmd_rw) begin
            exp_q.push_back({2'b00, wr_data});
            m_frames = 3; m_err = 1'b0;
          end else begin
            exp_q.push_back(TOK_S);
            exp_q.push_back({2'b00, dev_addr, 1'b1});
            exp_q.push_back(TOK_MNACK);
            m_frames = 4; m_rs = 1; m_err = 1'b0;
            m_rd_upd = 1'b1; m_rd_next = tgt_rd_val;
          end
        end
        exp_q.push_back(TOK_P);
        m_dur = CLK_DIV * 4 * (2 + m_rs + 9 * m_frames);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                         input logic [7:0] wd);
    cmd_rw = rw; dev_addr = dev; reg_addr = ra; wr_data = wd;
  endtask

  task automatic wait_acc(input int a0, input int limit);
    for (int i = 0; i < limit && n_acc == a0; i++) @(posedge clk);
    check("accept_seen", (n_acc != a0), 1);
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 2000 && n_done == d0; i++) @(posedge clk);
    check("done_seen", (n_done != d0), 1);
  endtask

  task automatic run_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                         input logic [7:0] wd);
    int a0, d0;
    a0 = n_acc; d0 = n_done;
    @(posedge clk); #1;
    set_cmd(rw, dev, ra, wd);
    cmd_valid = 1'b1;
    wait_acc(a0, 50);
    #1;
    cmd_valid = 1'b0;
    set_cmd(~rw, ~dev, ~ra, ~wd);
    wait_done(d0);
  endtask

  task automatic check_events(input string name, input logic [9:0] lit[$]);
    check({name, "_count"}, obs_q.size(), lit.size());
    for (int i = 0; i < lit.size() && i < obs_q.size(); i++) check(name, obs_q[i], lit[i]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int a0, d0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_scl", scl, 1);
    check("reset_sdaoe", sdaoe, 0);
    check("reset_sdao", sdao, 0);
    check("reset_ready", cmd_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_ack_err", ack_err, 0);
    check("reset_rd_data", rd_data, 8'h00);
    resetb = 1'b1;
    repeat (2) @(posedge clk);

    // 1: write 0x2C/0x05 <= 0xA7, all ACKed
    tgt_addr = 7'h2C; tgt_nack_reg = 1'b0; tgt_rd_val = 8'h5A;
    run_cmd(1'b0, 7'h2C, 8'h05, 8'hA7);
    check_events("t1_events", '{10'h100, 10'h058, 10'h005, 10'h0A7, 10'h200});
    check("t1_pulses", pulse_cnt, 27);
    check("t1_latency", (last_lat >= 462 && last_lat <= 466), 1);
    check("t1_ack_err", ack_err, 0);

    // 2: read 0x2C/0x10, target returns 0x3C
    tgt_rd_val = 8'h3C;
    run_cmd(1'b1, 7'h2C, 8'h10, 8'h00);
    check_events("t2_events", '{10'h100, 10'h058, 10'h010, 10'h100, 10'h059, 10'h301, 10'h200});
    check("t2_rd_data", rd_data, 8'h3C);
    check("t2_ack_err", ack_err, 0);
    check("t2_latency", (last_lat >= 622 && last_lat <= 626), 1);

    // 3: write to absent device 0x11
    run_cmd(1'b0, 7'h11, 8'h05, 8'h33);
    check_events("t3_events", '{10'h100, 10'h022, 10'h200});
    check("t3_ack_err", ack_err, 1);
    check("t3_rd_data", rd_data, 8'h3C);

    // 4: read with reg_addr NACKed
    tgt_nack_reg = 1'b1; tgt_rd_val = 8'h99;
    run_cmd(1'b1, 7'h2C, 8'h20, 8'h00);
    check_events("t4_events", '{10'h100, 10'h058, 10'h020, 10'h200});
    check("t4_ack_err", ack_err, 1);
    check("t4_rd_data", rd_data, 8'h3C);
    tgt_nack_reg = 1'b0;

    // boundary values: top address, read byte 0x81
    tgt_addr = 7'h7F; tgt_rd_val = 8'h81;
    run_cmd(1'b1, 7'h7F, 8'hFF, 8'h00);
    check("t4b_rd_data", rd_data, 8'h81);
    run_cmd(1'b0, 7'h7F, 8'h00, 8'h00);
    check("t4b_ack_err", ack_err, 0);
    tgt_addr = 7'h2C;

    // 5: back-to-back writes with cmd_valid held high
    a0 = n_acc; d0 = n_done;
    @(posedge clk); #1;
    set_cmd(1'b0, 7'h2C, 8'h01, 8'hC3);
    cmd_valid = 1'b1;
    wait_acc(a0, 50);
    #1;
    set_cmd(1'b0, 7'h2C, 8'h02, 8'h3C);
    wait_acc(a0 + 1, 1000);
    #1;
    cmd_valid = 1'b0;
    check("t5_b2b_gap", acc_cyc - done_cyc, 1);
    check("t5_first_done", n_done, d0 + 1);
    wait_done(d0 + 1);
    check_events("t5_events", '{10'h100, 10'h058, 10'h002, 10'h03C, 10'h200});

    // 6: reset in the middle of the data byte
    a0 = n_acc;
    @(posedge clk); #1;
    set_cmd(1'b0, 7'h2C, 8'h05, 8'hA7);
    cmd_valid = 1'b1;
    wait_acc(a0, 50);
    #1;
    cmd_valid = 1'b0;
    repeat (321) @(posedge clk);
    #2;
    check("t6_pre_scl", scl, 0);
    check("t6_pre_sdaoe", sdaoe, 1);
    resetb = 1'b0;
    #1;
    check("t6_rst_scl", scl, 1);
    check("t6_rst_sdaoe", sdaoe, 0);
    check("t6_rst_ready", cmd_ready, 1);
    check("t6_rst_busy", busy, 0);
    @(posedge clk); #2;
    resetb = 1'b1;
    repeat (2) @(posedge clk);
    run_cmd(1'b0, 7'h2C, 8'h06, 8'h5B);
    check_events("t6_events", '{10'h100, 10'h058, 10'h006, 10'h05B, 10'h200});
    check("t6_ack_err", ack_err, 0);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
